// File: rtl/lcd_access_arbiter.sv
// Round-robin arbiter sharing one LCD message driver among three requesters.
// Each transaction runs grant -> start pulse -> wait for done/timeout -> ack.
module lcd_access_arbiter #(
   parameter int MSG_W   = 8,
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [2:0]       req_i,
   input  logic [MSG_W-1:0] msg0_i,
   input  logic [MSG_W-1:0] msg1_i,
   input  logic [MSG_W-1:0] msg2_i,
   input  logic [2:0]       req_mask_i,
   input  logic             lcd_busy_i,
   input  logic             lcd_done_i,
   output logic             lcd_start_o,
   output logic [MSG_W-1:0] lcd_msg_o,
   output logic [2:0]       grant_o,
   output logic [1:0]       owner_o,
   output logic [2:0]       ack_o,
   output logic             timeout_err_o
);

   // state | meaning
   // IDLE  | arbitrate among eligible requesters while the driver is ready
   // ISSUE | start pulse to the driver, timer cleared
   // WAIT  | owner held until lcd_done or the timer reaches its terminal count
   // ACK   | ack pulse to the owner, grant released
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   localparam logic [1:0]      OWNER_NONE = 2'd3;
   localparam logic [TO_W-1:0] TIMER_TC   = TO_W'(TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [2:0]       grant_q, grant_d;
   logic [1:0]       owner_q, owner_d;
   logic [MSG_W-1:0] lcd_msg_q, lcd_msg_d;
   logic             lcd_start_q, lcd_start_d;
   logic [2:0]       ack_q, ack_d;
   logic             timeout_err_q, timeout_err_d;
   logic [TO_W-1:0]  timer_q, timer_d;
   logic [1:0]       last_owner_q, last_owner_d;

   logic [3:0]       elig;
   logic [1:0]       cand1, cand2, cand3;
   logic [1:0]       winner;
   logic [MSG_W-1:0] winner_msg;

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // Search order starts just after the previous owner, ending on it.
   always_comb begin
      elig  = {1'b0, req_i & req_mask_i};
      cand1 = next_idx(last_owner_q);
      cand2 = next_idx(cand1);
      cand3 = next_idx(cand2);
      if (elig[cand1])
         winner = cand1;
      else if (elig[cand2])
         winner = cand2;
      else
         winner = cand3;
      case (winner)
         2'd0:    winner_msg = msg0_i;
         2'd1:    winner_msg = msg1_i;
         default: winner_msg = msg2_i;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      owner_d       = owner_q;
      lcd_msg_d     = lcd_msg_q;
      lcd_start_d   = 1'b0;
      ack_d         = 3'b000;
      timeout_err_d = 1'b0;
      timer_d       = timer_q;
      last_owner_d  = last_owner_q;

      case (state_q)
         S_IDLE: begin
            if ((elig != 4'b0000) && !lcd_busy_i) begin
               state_d     = S_ISSUE;
               grant_d     = 3'(3'b001 << winner);
               owner_d     = winner;
               lcd_msg_d   = winner_msg;
               lcd_start_d = 1'b1;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Done on the terminal-count cycle takes precedence over the timeout.
            if (lcd_done_i || (timer_q == TIMER_TC)) begin
               state_d       = S_ACK;
               ack_d         = grant_q;
               timeout_err_d = !lcd_done_i;
               grant_d       = 3'b000;
               owner_d       = OWNER_NONE;
               last_owner_d  = owner_q;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         grant_q       <= 3'b000;
         owner_q       <= OWNER_NONE;
         lcd_msg_q     <= '0;
         lcd_start_q   <= 1'b0;
         ack_q         <= 3'b000;
         timeout_err_q <= 1'b0;
         timer_q       <= '0;
         last_owner_q  <= 2'd2;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         owner_q       <= owner_d;
         lcd_msg_q     <= lcd_msg_d;
         lcd_start_q   <= lcd_start_d;
         ack_q         <= ack_d;
         timeout_err_q <= timeout_err_d;
         timer_q       <= timer_d;
         last_owner_q  <= last_owner_d;
      end
   end

   assign lcd_start_o   = lcd_start_q;
   assign lcd_msg_o     = lcd_msg_q;
   assign grant_o       = grant_q;
   assign owner_o       = owner_q;
   assign ack_o         = ack_q;
   assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_lcd_access_arbiter.sv
// Bench for lcd_access_arbiter: arbitration vector table, scoreboard of
// expected transactions checked at start and ack, and hand-written corner cases.
module tb_lcd_access_arbiter;

   localparam int MSG_W   = 8;
   localparam int TIMEOUT = 16;
   localparam int TO_W    = 5;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [2:0]       req_i;
   logic [MSG_W-1:0] msg0_i, msg1_i, msg2_i;
   logic [2:0]       req_mask_i;
   logic             lcd_busy_i;
   logic             lcd_done_i;
   logic             lcd_start_o;
   logic [MSG_W-1:0] lcd_msg_o;
   logic [2:0]       grant_o;
   logic [1:0]       owner_o;
   logic [2:0]       ack_o;
   logic             timeout_err_o;

   lcd_access_arbiter #(.MSG_W(MSG_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
      .msg0_i(msg0_i), .msg1_i(msg1_i), .msg2_i(msg2_i),
      .req_mask_i(req_mask_i), .lcd_busy_i(lcd_busy_i), .lcd_done_i(lcd_done_i),
      .lcd_start_o(lcd_start_o), .lcd_msg_o(lcd_msg_o), .grant_o(grant_o),
      .owner_o(owner_o), .ack_o(ack_o), .timeout_err_o(timeout_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0]       grant;
      logic [1:0]       owner;
      logic [MSG_W-1:0] msg;
      logic             err;
   } txn_t;

   txn_t sb[$];

   typedef struct {
      logic [2:0] req;
      logic [2:0] mask;
      logic       busy;
      logic [2:0] exp_grant;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic txn_t mk(input int idx, input logic [MSG_W-1:0] m, input logic e);
      txn_t t;
      t.grant = 3'(3'b001 << idx);
      t.owner = 2'(idx);
      t.msg   = m;
      t.err   = e;
      return t;
   endfunction

   task automatic wait_start(input int max_cycles);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < max_cycles; c++) begin
         tick();
         if (lcd_start_o) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL wait_start: no lcd_start within %0d cycles", max_cycles);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      sb.delete();
   endtask

   // Scoreboard monitor: lcd_start checked against the head entry, ack pops it.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_i) begin
            if (lcd_start_o) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected start: grant %0h, expected none", grant_o);
               end else begin
                  check("start grant", 32'(grant_o), 32'(sb[0].grant));
                  check("start owner", 32'(owner_o), 32'(sb[0].owner));
                  check("start msg", 32'(lcd_msg_o), 32'(sb[0].msg));
               end
            end
            if (ack_o != 3'b000) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected ack: ack %0h, expected 0", ack_o);
               end else begin
                  txn_t e;
                  e = sb.pop_front();
                  check("ack vector", 32'(ack_o), 32'(e.grant));
                  check("ack timeout_err", 32'(timeout_err_o), 32'(e.err));
                  check("ack grant released", 32'(grant_o), 32'd0);
                  check("ack owner none", 32'(owner_o), 32'd3);
               end
            end else if (timeout_err_o) begin
               n_cmp++;
               n_err++;
               $display("FAIL timeout_err without ack: got 1, expected 0");
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

   initial begin
      int cnt;
      int idx;
      logic [MSG_W-1:0] m;
      logic [2:0] rr_exp [4];

      rst_i = 1'b1; req_i = 3'b000; req_mask_i = 3'b111; lcd_busy_i = 1'b0; lcd_done_i = 1'b0;
      msg0_i = 8'h00; msg1_i = 8'h00; msg2_i = 8'h00;

      // expected grants from reset (last owner = requester 2)
      vecs[0]  = '{3'b010, 3'b111, 1'b0, 3'b010};
      vecs[1]  = '{3'b111, 3'b111, 1'b0, 3'b100};
      vecs[2]  = '{3'b111, 3'b111, 1'b0, 3'b001};
      vecs[3]  = '{3'b111, 3'b111, 1'b0, 3'b010};
      vecs[4]  = '{3'b011, 3'b111, 1'b0, 3'b001};
      vecs[5]  = '{3'b101, 3'b011, 1'b0, 3'b001};
      vecs[6]  = '{3'b111, 3'b000, 1'b0, 3'b000};
      vecs[7]  = '{3'b110, 3'b111, 1'b1, 3'b000};
      vecs[8]  = '{3'b110, 3'b111, 1'b0, 3'b010};
      vecs[9]  = '{3'b101, 3'b111, 1'b0, 3'b100};
      vecs[10] = '{3'b011, 3'b110, 1'b0, 3'b010};
      vecs[11] = '{3'b001, 3'b111, 1'b0, 3'b001};

      #12;
      check("reset grant", 32'(grant_o), 32'd0);
      check("reset owner", 32'(owner_o), 32'd3);
      check("reset start", 32'(lcd_start_o), 32'd0);
      check("reset msg", 32'(lcd_msg_o), 32'd0);
      check("reset ack", 32'(ack_o), 32'd0);
      check("reset timeout_err", 32'(timeout_err_o), 32'd0);
      rst_i = 1'b0;
      tick();

      // arbitration vector table
      for (int i = 0; i < 12; i++) begin
         req_i = vecs[i].req; req_mask_i = vecs[i].mask; lcd_busy_i = vecs[i].busy;
         msg0_i = 8'hA0 | 8'(i); msg1_i = 8'hB0 | 8'(i); msg2_i = 8'hC0 | 8'(i);
         idx = (vecs[i].exp_grant == 3'b001) ? 0 : (vecs[i].exp_grant == 3'b010) ? 1 : 2;
         m = (idx == 0) ? msg0_i : (idx == 1) ? msg1_i : msg2_i;
         if (vecs[i].exp_grant != 3'b000) sb.push_back(mk(idx, m, 1'b0));
         tick();
         check($sformatf("vec%0d grant", i), 32'(grant_o), 32'(vecs[i].exp_grant));
         check($sformatf("vec%0d start", i), 32'(lcd_start_o), 32'(vecs[i].exp_grant != 3'b000));
         if (vecs[i].exp_grant != 3'b000) begin
            tick();
            lcd_done_i = 1'b1;
            tick();
            lcd_done_i = 1'b0;
            req_i = 3'b000;
            tick();
         end else begin
            req_i = 3'b000;
            lcd_busy_i = 1'b0;
         end
      end

      // round-robin with all three requesting continuously
      do_reset();
      req_mask_i = 3'b111; msg0_i = 8'h01; msg1_i = 8'h02; msg2_i = 8'h03;
      rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
      sb.push_back(mk(0, 8'h01, 1'b0)); sb.push_back(mk(1, 8'h02, 1'b0));
      sb.push_back(mk(2, 8'h03, 1'b0)); sb.push_back(mk(0, 8'h01, 1'b0));
      req_i = 3'b111;
      for (int k = 0; k < 4; k++) begin
         wait_start(10);
         check($sformatf("rr grant %0d", k), 32'(grant_o), 32'(rr_exp[k]));
         tick();
         tick();
         lcd_done_i = 1'b1;
         tick();
         lcd_done_i = 1'b0;
         if (k == 3) req_i = 3'b000;
      end
      tick();

      // single request, done five cycles after start
      msg1_i = 8'h2A; req_i = 3'b010;
      sb.push_back(mk(1, 8'h2A, 1'b0));
      tick();
      check("single grant", 32'(grant_o), 32'h2);
      check("single owner", 32'(owner_o), 32'd1);
      check("single msg", 32'(lcd_msg_o), 32'h2A);
      check("single start", 32'(lcd_start_o), 32'd1);
      tick();
      check("single start one cycle", 32'(lcd_start_o), 32'd0);
      repeat (4) tick();
      lcd_done_i = 1'b1;
      tick();
      lcd_done_i = 1'b0;
      check("single ack", 32'(ack_o), 32'h2);
      check("single ack err", 32'(timeout_err_o), 32'd0);
      req_i = 3'b000;
      tick();
      check("single ack one cycle", 32'(ack_o), 32'd0);
      check("single grant idle", 32'(grant_o), 32'd0);

      // gating by mask and by lcd_busy
      req_mask_i = 3'b101; req_i = 3'b010;
      cnt = 0;
      repeat (50) begin tick(); if (grant_o != 3'b000) cnt++; end
      check("masked grants", 32'(cnt), 32'd0);
      req_i = 3'b001; lcd_busy_i = 1'b1; msg0_i = 8'h5C;
      cnt = 0;
      repeat (5) begin tick(); if (grant_o != 3'b000) cnt++; end
      check("busy grants", 32'(cnt), 32'd0);
      sb.push_back(mk(0, 8'h5C, 1'b0));
      lcd_busy_i = 1'b0;
      tick();
      check("busy release grant", 32'(grant_o), 32'h1);
      tick();
      lcd_done_i = 1'b1;
      tick();
      lcd_done_i = 1'b0;
      req_i = 3'b000;
      tick();

      // timeout: no done, exactly TIMEOUT wait cycles
      req_mask_i = 3'b111; msg2_i = 8'h7E; req_i = 3'b100;
      sb.push_back(mk(2, 8'h7E, 1'b1));
      wait_start(10);
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         cnt++;
         if (ack_o != 3'b000) break;
      end
      check("timeout start-to-ack cycles", 32'(cnt), 32'(TIMEOUT + 1));
      check("timeout err flag", 32'(timeout_err_o), 32'd1);
      req_i = 3'b000;
      tick();

      // done on the final count cycle wins
      req_i = 3'b100;
      sb.push_back(mk(2, 8'h7E, 1'b0));
      wait_start(10);
      repeat (TIMEOUT) tick();
      check("last wait grant held", 32'(grant_o), 32'h4);
      check("last wait no ack", 32'(ack_o), 32'd0);
      lcd_done_i = 1'b1;
      tick();
      lcd_done_i = 1'b0;
      check("late done ack", 32'(ack_o), 32'h4);
      check("late done err", 32'(timeout_err_o), 32'd0);
      req_i = 3'b000;
      tick();

      // mid-transaction changes do not disturb the owner
      msg0_i = 8'h55; req_i = 3'b001;
      sb.push_back(mk(0, 8'h55, 1'b0));
      wait_start(10);
      req_i = 3'b000; req_mask_i = 3'b110; msg0_i = 8'hAA;
      tick();
      tick();
      check("mid msg latched", 32'(lcd_msg_o), 32'h55);
      check("mid grant held", 32'(grant_o), 32'h1);
      lcd_done_i = 1'b1;
      tick();
      lcd_done_i = 1'b0;
      check("mid ack", 32'(ack_o), 32'h1);
      tick();
      check("mid ack once", 32'(ack_o), 32'd0);

      // asynchronous reset during WAIT
      req_mask_i = 3'b111; msg1_i = 8'h33; req_i = 3'b010;
      sb.push_back(mk(1, 8'h33, 1'b0));
      wait_start(10);
      tick();
      #2 rst_i = 1'b1;
      #1;
      check("abort grant", 32'(grant_o), 32'd0);
      check("abort owner", 32'(owner_o), 32'd3);
      check("abort start", 32'(lcd_start_o), 32'd0);
      check("abort ack", 32'(ack_o), 32'd0);
      sb.delete();
      req_i = 3'b000;
      tick();
      rst_i = 1'b0;
      req_i = 3'b111;
      sb.push_back(mk(0, 8'hAA, 1'b0));
      tick();
      check("post-reset grant", 32'(grant_o), 32'h1);
      check("post-reset start", 32'(lcd_start_o), 32'd1);
      tick();
      lcd_done_i = 1'b1;
      tick();
      lcd_done_i = 1'b0;
      req_i = 3'b000;
      tick();
      tick();
      check("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_access_arbiter.md
Name: lcd_access_arbiter

Overview:
- Shares the single LCD message driver among three requesters: access control (0), game (1) and scoreboard (2).
- Process control gates which requesters are eligible through a mask.
- Arbitration is round-robin, one message transaction at a time.
- Sequence per transaction: grant, start pulse to the driver, wait for the driver's done or a timeout, acknowledge the owner.

Parameters:
- MSG_W, 8, width of each message code and of lcd_msg.
- TIMEOUT, 1023, maximum number of WAIT cycles before a transaction is force-closed (must be ≥2).
- TO_W, 10, timer width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  3  per-requester request level; held until that requester's ack.
- msg0  input  MSG_W  message code from requester 0.
- msg1  input  MSG_W  message code from requester 1.
- msg2  input  MSG_W  message code from requester 2.
- req_mask  input  3  eligibility mask from process control; 1 = may be granted.
- lcd_busy  input  1  driver not ready; no new grant while high.
- lcd_done  input  1  one-cycle pulse, driver finished the current message.
- lcd_start  output  1  one-cycle pulse, driver latches lcd_msg.
- lcd_msg  output  MSG_W  message code of the current owner, registered.
- grant  output  3  one-hot owner indication, zero when idle.
- owner  output  2  owner index 0..2; 3 = none.
- ack  output  3  one-cycle completion pulse to the owner.
- timeout_err  output  1  one-cycle pulse coincident with ack when the transaction timed out.

Behaviour:
- Reset, asynchronous, immediate:
  - state=IDLE, grant=0, owner=3, lcd_start=0, lcd_msg=0, ack=0, timeout_err=0, timer=0.
  - last_owner=2, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - eligible = req & req_mask.
  - If eligible≠0 and lcd_busy=0: winner = first set bit searching last_owner+1, +2, +3 (mod 3).
  - Register grant/owner/lcd_msg from the winner's msg; go to ISSUE.
  - Otherwise stay in IDLE; outputs hold their idle values.
- ISSUE (exactly 1 cycle):
  - lcd_start=1; grant, owner and lcd_msg valid.
  - timer cleared; go to WAIT.
  - lcd_done in this cycle is ignored.
- WAIT:
  - lcd_start=0; grant, owner and lcd_msg held stable.
  - lcd_done=1: go to ACK, err=0.
  - Otherwise, if timer==TIMEOUT-1: go to ACK, err=1.
  - Otherwise: timer+1, stay.
  - Maximum residence is TIMEOUT cycles. lcd_done on the final count cycle wins (err=0).
- ACK (exactly 1 cycle):
  - ack[owner]=1; timeout_err=err.
  - grant=0 and owner=3 in this same cycle.
  - last_owner <= owner; go to IDLE.
- Latency:
  - req asserted in an IDLE cycle t (lcd_busy=0) gives grant/lcd_start in cycle t+1.
  - Minimum transaction is 4 cycles (IDLE, ISSUE, WAIT with done, ACK).
- Requester contract: a requester drops req on the edge ending its ack cycle. The following IDLE cycle therefore does not re-grant it unless it re-requests.
- Mid-transaction changes:
  - Dropping req or clearing req_mask for the owner after grant does not abort. The transaction runs to done or timeout, and ack is still issued.
  - Changes to msgN after ISSUE have no effect (lcd_msg is latched at grant).
- Simultaneous requests: resolved purely by the round-robin order. No requester is granted twice while another eligible requester waits.
- lcd_busy is sampled only in IDLE.
- rst asserted in any state aborts immediately to reset values. No ack or timeout_err is issued for the aborted transaction.

Test Plan:
- Reset: assert rst mid-simulation, asynchronously between edges → all outputs drop at once to grant=0, owner=3, lcd_start=0, ack=0; next arbitration favours requester 0.
- Single request: req=3'b010, msg1=8'h2A, mask=3'b111 → next cycle grant=3'b010, owner=1, lcd_msg=8'h2A, lcd_start high for exactly 1 cycle; lcd_done pulsed 5 cycles later → ack=3'b010 for 1 cycle the cycle after done, timeout_err=0, then grant=0.
- Round-robin fairness: req=3'b111 held (requesters re-raise req after each ack), done returned 2 cycles after each start → grant sequence 001, 010, 100, 001.
- Gating: mask=3'b101 with req=3'b010 → no grant for 50 cycles. Then req=3'b001 with lcd_busy=1 → no grant. Release lcd_busy → grant=3'b001 on the next cycle.
- Timeout (TIMEOUT=16): grant requester 2, never pulse done → exactly 16 WAIT cycles, then ack=3'b100 with timeout_err=1 in the same cycle. Repeat with done on the 16th WAIT cycle → ack with timeout_err=0.
- Mid-transaction robustness: after grant to requester 0, drop req[0], clear mask[0] and change msg0 → lcd_msg unchanged, transaction completes on done, ack[0] pulses once. Then rst during WAIT → immediate idle, no ack.
